// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory port arbiter.
// Holds the arbiter state encoding, the default memory geometry and the
// instruction substituted for fetches that cannot return real data.
package imem_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } imem_state_e;

  localparam int          IMEM_DEPTH    = 64;
  localparam int          IMEM_AW       = 6;
  localparam int          IMEM_STARVE_W = 4;
  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating loader-starvation counter.
// Counts cycles the loader was denied while it had a request pending,
// stops at LIMIT, and flags when the limit has been reached.
module imem_starve_ctr #(
  parameter int W     = 4,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_lim
);

  localparam logic [W-1:0] LIM_V = LIMIT[W-1:0];

  logic [W-1:0] r_cnt;

  // Clear wins over increment; increment stops once the limit is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIM_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_lim = (r_cnt == LIM_V);

endmodule

// File: rtl/imem_load_arbiter.sv
// Single-port instruction memory arbiter between IF-stage fetch and the
// program loader. After reset the loader owns the port until it marks its
// last boot word; afterwards fetch has priority, with a starvation counter
// that periodically forces a loader slot.
// Optional build macro IMEM_BOUNDS_CHECK_EN: fetches at or beyond the end of
// the array return a NOP and pulse fetch_fault instead of wrapping.
module imem_load_arbiter
  import imem_pkg::*;
#(
  parameter int          DEPTH      = IMEM_DEPTH,
  parameter int          AW         = IMEM_AW,
  parameter int          STARVE_LIM = 4,
  parameter logic [31:0] NOP_WORD   = IMEM_NOP_WORD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_pc,
  output logic          fetch_gnt,
  output logic          fetch_valid,
  output logic [31:0]   fetch_instr,
  output logic          fetch_misalign,
  output logic          stall,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          boot_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
`ifdef IMEM_BOUNDS_CHECK_EN
  ,
  output logic          fetch_fault
`endif
);

  imem_state_e r_state;
  logic        r_boot_done;
  logic        r_fetch_valid;
  logic [31:0] r_fetch_instr;
  logic        r_fetch_misalign;
`ifdef IMEM_BOUNDS_CHECK_EN
  logic        r_fetch_fault;
`endif

  logic w_run;
  logic w_at_lim;
  logic w_force;
  logic w_fetch_gnt;
  logic w_ld_ready;
  logic w_starve_inc;
  logic w_misalign;
  logic w_oob;
  logic w_unused_pc_hi;

  // Upper PC bits only matter when bounds checking is built in.
  assign w_unused_pc_hi = ^fetch_pc[31:AW+2];

`ifdef IMEM_BOUNDS_CHECK_EN
  assign w_oob = |fetch_pc[31:AW+2];
`else
  assign w_oob = 1'b0;
`endif

  assign w_run        = (r_state == RUN);
  assign w_force      = w_run && w_at_lim && ld_valid;
  assign w_fetch_gnt  = w_run && fetch_req && !w_force;
  assign w_ld_ready   = !rst && ld_valid && (!w_run || w_force || !fetch_req);
  assign w_starve_inc = w_fetch_gnt && ld_valid;
  assign w_misalign   = (fetch_pc[1:0] != 2'b00);

  imem_starve_ctr #(
    .W     (IMEM_STARVE_W),
    .LIMIT (STARVE_LIM)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_starve_inc),
    .i_clr    (!w_starve_inc),
    .o_at_lim (w_at_lim)
  );

  // Arbiter state, boot completion flag and the registered fetch response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= BOOT;
      r_boot_done      <= 1'b0;
      r_fetch_valid    <= 1'b0;
      r_fetch_instr    <= '0;
      r_fetch_misalign <= 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
      r_fetch_fault    <= 1'b0;
`endif
    end else begin
      case (r_state)
        BOOT: begin
          if (ld_valid && ld_last) begin
            r_state     <= RUN;
            r_boot_done <= 1'b1;
          end
        end
        RUN:     r_state <= RUN;
        default: r_state <= BOOT;
      endcase

      if (w_fetch_gnt) begin
        r_fetch_valid    <= 1'b1;
        r_fetch_misalign <= w_misalign;
        r_fetch_instr    <= (w_misalign || w_oob) ? NOP_WORD : mem_rdata;
`ifdef IMEM_BOUNDS_CHECK_EN
        r_fetch_fault    <= w_oob;
`endif
      end else begin
        r_fetch_valid    <= 1'b0;
        r_fetch_misalign <= 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
        r_fetch_fault    <= 1'b0;
`endif
      end
    end
  end

  assign fetch_gnt      = w_fetch_gnt;
  assign stall          = fetch_req && !w_fetch_gnt;
  assign ld_ready       = w_ld_ready;
  assign boot_done      = r_boot_done;
  assign fetch_valid    = r_fetch_valid;
  assign fetch_instr    = r_fetch_instr;
  assign fetch_misalign = r_fetch_misalign;
`ifdef IMEM_BOUNDS_CHECK_EN
  assign fetch_fault    = r_fetch_fault;
`endif

  // The loader path is selected whenever fetch is not granted, so the write
  // address is already on the bus in the cycle ld_ready rises.
  assign mem_we    = w_ld_ready;
  assign mem_addr  = w_fetch_gnt ? fetch_pc[AW+1:2] : ld_addr;
  assign mem_wdata = ld_data;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed self-checking bench for imem_load_arbiter with a behavioural
// 64-word memory array attached to the mem_* port.
module tb_imem_load_arbiter;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_misalign;
  logic        stall;
  logic        ld_valid;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        boot_done;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef IMEM_BOUNDS_CHECK_EN
  logic        fetch_fault;
`endif

  logic [31:0] mem [64];
  logic [31:0] boot_data [4];

  int n_checks;
  int n_fail;

  imem_load_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req      (fetch_req),
    .fetch_pc       (fetch_pc),
    .fetch_gnt      (fetch_gnt),
    .fetch_valid    (fetch_valid),
    .fetch_instr    (fetch_instr),
    .fetch_misalign (fetch_misalign),
    .stall          (stall),
    .ld_valid       (ld_valid),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_last        (ld_last),
    .ld_ready       (ld_ready),
    .boot_done      (boot_done),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
`ifdef IMEM_BOUNDS_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic test_reset();
    rst = 1'b1;
    fetch_req = 1'b1;
    fetch_pc = 32'd4;
    ld_valid = 1'b1;
    ld_addr = 6'd7;
    ld_data = 32'hFFFF_FFFF;
    ld_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0h exp=0", fetch_valid); end
    n_checks++; if (fetch_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%08h exp=00000000", fetch_instr); end
    n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%0h exp=0", fetch_misalign); end
    n_checks++; if (boot_done !== 1'b0) begin n_fail++; $display("FAIL reset_boot_done got=%0h exp=0", boot_done); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
    n_checks++; if (fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got=%0h exp=0", fetch_gnt); end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last = 1'b0;
    fetch_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_boot_load();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fetch_req = 1'b1;
      fetch_pc = 32'd4;
      ld_valid = 1'b1;
      ld_addr = 6'(i);
      ld_data = boot_data[i];
      ld_last = (i == 3);
      #1;
      n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL boot_we[%0d] got=%0h exp=1", i, mem_we); end
      n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL boot_ready[%0d] got=%0h exp=1", i, ld_ready); end
      n_checks++; if (fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL boot_gnt[%0d] got=%0h exp=0", i, fetch_gnt); end
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL boot_stall[%0d] got=%0h exp=1", i, stall); end
      n_checks++; if (mem_addr !== 6'(i)) begin n_fail++; $display("FAIL boot_addr[%0d] got=%0d exp=%0d", i, mem_addr, i); end
      n_checks++; if (mem_wdata !== boot_data[i]) begin n_fail++; $display("FAIL boot_wdata[%0d] got=%08h exp=%08h", i, mem_wdata, boot_data[i]); end
      n_checks++; if (boot_done !== 1'b0) begin n_fail++; $display("FAIL boot_done_early[%0d] got=%0h exp=0", i, boot_done); end
    end
    @(posedge clk);
    #1;
    n_checks++; if (boot_done !== 1'b1) begin n_fail++; $display("FAIL boot_done got=%0h exp=1", boot_done); end
    @(negedge clk);
    fetch_req = 1'b0;
    ld_valid = 1'b0;
    ld_last = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    fetch_req = 1'b1;
    fetch_pc = 32'd4;
    #1;
    n_checks++; if (fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL fetch_gnt got=%0h exp=1", fetch_gnt); end
    n_checks++; if (mem_addr !== 6'd1) begin n_fail++; $display("FAIL fetch_addr got=%0d exp=1", mem_addr); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fetch_stall got=%0h exp=0", stall); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_we got=%0h exp=0", mem_we); end
    @(posedge clk);
    #1;
    n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid got=%0h exp=1", fetch_valid); end
    n_checks++; if (fetch_instr !== 32'h403080B3) begin n_fail++; $display("FAIL fetch_instr got=%08h exp=403080b3", fetch_instr); end
    n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL fetch_misalign got=%0h exp=0", fetch_misalign); end
    @(negedge clk);
    fetch_pc = 32'd6;
    @(posedge clk);
    #1;
    n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL mis_valid got=%0h exp=1", fetch_valid); end
    n_checks++; if (fetch_instr !== 32'h00000013) begin n_fail++; $display("FAIL mis_instr got=%08h exp=00000013", fetch_instr); end
    n_checks++; if (fetch_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag got=%0h exp=1", fetch_misalign); end
    @(negedge clk);
    fetch_req = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%0h exp=0", fetch_valid); end
    n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL idle_misalign got=%0h exp=0", fetch_misalign); end
    n_checks++; if (fetch_instr !== 32'h00000013) begin n_fail++; $display("FAIL idle_hold got=%08h exp=00000013", fetch_instr); end
  endtask

  task automatic test_starvation();
    logic exp_ld;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      fetch_req = 1'b1;
      fetch_pc = 32'd8;
      ld_valid = 1'b1;
      ld_addr = 6'd20;
      ld_data = 32'hDEAD_BEEF;
      #1;
      exp_ld = (c == 5);
      n_checks++; if (fetch_gnt !== !exp_ld) begin n_fail++; $display("FAIL starve_gnt[c%0d] got=%0h exp=%0h", c, fetch_gnt, !exp_ld); end
      n_checks++; if (ld_ready !== exp_ld) begin n_fail++; $display("FAIL starve_ready[c%0d] got=%0h exp=%0h", c, ld_ready, exp_ld); end
      n_checks++; if (stall !== exp_ld) begin n_fail++; $display("FAIL starve_stall[c%0d] got=%0h exp=%0h", c, stall, exp_ld); end
      n_checks++; if (mem_we !== exp_ld) begin n_fail++; $display("FAIL starve_we[c%0d] got=%0h exp=%0h", c, mem_we, exp_ld); end
      @(posedge clk);
      #1;
      n_checks++; if (fetch_valid !== !exp_ld) begin n_fail++; $display("FAIL starve_valid[c%0d] got=%0h exp=%0h", c, fetch_valid, !exp_ld); end
      n_checks++; if (fetch_instr !== 32'h00208133) begin n_fail++; $display("FAIL starve_instr[c%0d] got=%08h exp=00208133", c, fetch_instr); end
    end
    @(negedge clk);
    fetch_req = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic test_idle_write();
    @(negedge clk);
    fetch_req = 1'b0;
    ld_valid = 1'b1;
    ld_addr = 6'd10;
    ld_data = 32'h1234_5678;
    ld_last = 1'b1;
    #1;
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got=%0h exp=1", ld_ready); end
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL idle_we got=%0h exp=1", mem_we); end
    n_checks++; if (mem_addr !== 6'd10) begin n_fail++; $display("FAIL idle_addr got=%0d exp=10", mem_addr); end
    @(posedge clk);
    #1;
    n_checks++; if (boot_done !== 1'b1) begin n_fail++; $display("FAIL run_last_ignored got=%0h exp=1", boot_done); end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last = 1'b0;
    fetch_req = 1'b1;
    fetch_pc = 32'd40;
    @(posedge clk);
    #1;
    n_checks++; if (fetch_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL idle_readback got=%08h exp=12345678", fetch_instr); end
    @(negedge clk);
    fetch_pc = 32'd80;
    @(posedge clk);
    #1;
    n_checks++; if (fetch_instr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL forced_readback got=%08h exp=deadbeef", fetch_instr); end
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [31:0] exp_260;
    logic [31:0] exp_256;
`ifdef IMEM_BOUNDS_CHECK_EN
    exp_260 = 32'h00000013;
    exp_256 = 32'h00000013;
`else
    exp_260 = 32'h403080B3;
    exp_256 = 32'h00000000;
`endif
    @(negedge clk);
    fetch_req = 1'b1;
    fetch_pc = 32'd260;
    @(posedge clk);
    #1;
    n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL oor260_valid got=%0h exp=1", fetch_valid); end
    n_checks++; if (fetch_instr !== exp_260) begin n_fail++; $display("FAIL oor260_instr got=%08h exp=%08h", fetch_instr, exp_260); end
`ifdef IMEM_BOUNDS_CHECK_EN
    n_checks++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL oor260_fault got=%0h exp=1", fetch_fault); end
`endif
    @(negedge clk);
    fetch_pc = 32'd256;
    @(posedge clk);
    #1;
    n_checks++; if (fetch_instr !== exp_256) begin n_fail++; $display("FAIL oor256_instr got=%08h exp=%08h", fetch_instr, exp_256); end
    @(negedge clk);
    fetch_pc = 32'd4;
    @(posedge clk);
    #1;
    n_checks++; if (fetch_instr !== 32'h403080B3) begin n_fail++; $display("FAIL inrange_instr got=%08h exp=403080b3", fetch_instr); end
`ifdef IMEM_BOUNDS_CHECK_EN
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL inrange_fault got=%0h exp=0", fetch_fault); end
`endif
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    fetch_req = 1'b1;
    fetch_pc = 32'd4;
    @(posedge clk);
    #1;
    n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid got=%0h exp=1", fetch_valid); end
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%0h exp=0", fetch_valid); end
    n_checks++; if (boot_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_boot_done got=%0h exp=0", boot_done); end
    n_checks++; if (fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_rst_gnt got=%0h exp=0", fetch_gnt); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_checks++; if (fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL reboot_gnt[%0d] got=%0h exp=0", c, fetch_gnt); end
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reboot_stall[%0d] got=%0h exp=1", c, stall); end
      n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reboot_valid[%0d] got=%0h exp=0", c, fetch_valid); end
    end
    @(negedge clk);
    ld_valid = 1'b1;
    ld_addr = 6'd5;
    ld_data = 32'h0000_0517;
    ld_last = 1'b1;
    #1;
    n_checks++; if (fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL reboot_last_gnt got=%0h exp=0", fetch_gnt); end
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reboot_last_ready got=%0h exp=1", ld_ready); end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last = 1'b0;
    #1;
    n_checks++; if (boot_done !== 1'b1) begin n_fail++; $display("FAIL reboot_done got=%0h exp=1", boot_done); end
    n_checks++; if (fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL reboot_gnt_after got=%0h exp=1", fetch_gnt); end
    @(posedge clk);
    #1;
    n_checks++; if (fetch_instr !== 32'h403080B3) begin n_fail++; $display("FAIL reboot_kept_word got=%08h exp=403080b3", fetch_instr); end
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    boot_data[0] = 32'h0000_0000;
    boot_data[1] = 32'h4030_80B3;
    boot_data[2] = 32'h0020_8133;
    boot_data[3] = 32'h00A1_0693;
    rst = 1'b1;
    fetch_req = 1'b0;
    fetch_pc = 32'h0;
    ld_valid = 1'b0;
    ld_addr = 6'h0;
    ld_data = 32'h0;
    ld_last = 1'b0;

    test_reset();
    test_boot_load();
    test_fetch();
    test_starvation();
    test_idle_write();
    test_out_of_range();
    test_reset_mid_run();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
Owns the single port of the 64-word instruction memory and shares it between pipeline fetch (read) and a program loader (write).
- After reset it sequences a boot load: the loader owns the port and fetch is stalled until the loader signals its last word.
- After boot, fetch has priority. A starvation counter guarantees the loader a slot for run-time patching.
- Sits between the IF stage / PC register and the memory array.

Parameters:
DEPTH, 64, memory depth in 32-bit words (power of two)
AW, 6, word-address width, log2(DEPTH)
STARVE_LIM, 4, consecutive denied loader cycles before the loader is forced a grant (1..15)
NOP_WORD, 32'h0000_0013, instruction returned on misaligned/faulted fetch (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
fetch_req  in  1  IF stage requests an instruction
fetch_pc  in  32  byte address from PC
fetch_gnt  out  1  request accepted this cycle (combinational)
fetch_valid  out  1  fetch_instr valid, 1 cycle after grant
fetch_instr  out  32  registered instruction
fetch_misalign  out  1  pulse with fetch_valid when fetch_pc[1:0]!=0
stall  out  1  high whenever fetch_req && !fetch_gnt
ld_valid  in  1  loader write request
ld_addr  in  AW  loader word address
ld_data  in  32  loader write data
ld_last  in  1  marks final boot word
ld_ready  out  1  loader write accepted this cycle (combinational)
boot_done  out  1  high once boot load completes
mem_we  out  1  array write enable
mem_addr  out  AW  array word address
mem_wdata  out  32  array write data
mem_rdata  in  32  array combinational read data

Behaviour:
- Reset (async, rst=1): state=BOOT; fetch_valid=0, fetch_instr=0, fetch_misalign=0, boot_done=0, starve_cnt=0. mem_we=0 while rst is asserted. Reset mid-load or mid-run always returns to BOOT; already-written words are not cleared.
- BOOT: fetch_gnt=0. ld_ready=ld_valid. A write occurs when ld_valid is high (mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data). If ld_last is accepted, move to RUN and set boot_done=1 from the next cycle.
- RUN arbitration, per cycle:
  - Force grant: starve_cnt==STARVE_LIM && ld_valid → loader granted, fetch denied (stall=1), starve_cnt←0.
  - Otherwise fetch_req → fetch granted, mem_addr=fetch_pc[AW+1:2], mem_we=0. starve_cnt increments (saturating) when ld_valid is high, else clears.
  - Otherwise ld_valid → loader granted, starve_cnt←0.
- ld_last is ignored in RUN.
- Fetch latency is 1 cycle. On grant, at the next edge: fetch_valid←1, fetch_instr←mem_rdata. If fetch_pc[1:0]!=0, instead fetch_instr←NOP_WORD and fetch_misalign←1.
- With no grant, fetch_valid←0 and fetch_instr holds its value.
- Address wrap: fetch_pc bits above AW+1 are ignored (modulo DEPTH), unless the optional feature is enabled.
- Simultaneous write and fetch to the same word never occur; the port is exclusive.

Optional Feature:
IMEM_BOUNDS_CHECK_EN:
- Defined: a fetch with fetch_pc >= 4*DEPTH returns NOP_WORD with fetch_valid=1 and asserts extra output fetch_fault (1-cycle pulse, reset 0).
- Undefined: no fetch_fault port; addresses wrap modulo DEPTH.

Decomposition:
- Shared package imem_pkg:
  - state enum {BOOT, RUN}
  - NOP_WORD constant
  - default DEPTH/AW constants
- Sub-module imem_starve_ctr: saturating counter with clear and compare-to-limit output. The arbiter FSM and fetch register stay in the top block.

Test Plan:
- Boot load: rst pulse, then ld_valid for addr 0..3 (data 0,0x403080B3,...,0x00A10693) with ld_last on addr 3 → 4 writes; boot_done=1 on the cycle after; fetch_gnt=0 throughout BOOT.
- Fetch after boot: fetch_req with pc=4 → fetch_valid next cycle, fetch_instr=0x403080B3; pc=6 → fetch_instr=0x00000013, fetch_misalign=1.
- Starvation: fetch_req held high and ld_valid held high in RUN, STARVE_LIM=4 → loader granted on cycle 5, stall=1 that cycle, fetch resumes cycle 6.
- Idle write: fetch_req=0, ld_valid=1, addr 10 → ld_ready=1 the same cycle; a later fetch of pc=40 returns the written data.
- Reset mid-run: rst asserted during a granted fetch → fetch_valid=0 and boot_done=0 immediately; state=BOOT; fetch blocked until the next ld_last.
- Out of range: pc=256 → wraps to word 0 (default build); with IMEM_BOUNDS_CHECK_EN, returns NOP with fetch_fault=1.
